tcm_ext_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the external (second) port of the TCM dual-port RAM. Typical requesters are a debug/UART loader and a DMA engine. The block latches one command at a time and drives it onto the TCM ext_* interface with the timing that interface requires. It captures read data, returns a one-cycle ack to the winning requester, then idles for a programmable gap so the CPU data port regains the RAM.

---
 rtl/tcm_ext_arbiter_pkg.sv | 20 ++
 rtl/tcm_rr_pick2.sv | 21 ++
 rtl/tcm_ext_arbiter.sv | 154 +++++++++++++++
 tb/tb_tcm_ext_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_ext_arbiter_pkg.sv
// Shared definitions for the TCM external-port arbiter: state encoding,
// gap counter width and the request-pending helper.
package tcm_ext_arbiter_pkg;

    localparam int GAP_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_ACK     = 3'd3,
        ST_GAP     = 3'd4
    } arb_state_t;

    // A requester is pending on a read or on any write strobe.
    function automatic logic cmd_pending(input logic rd, input logic [3:0] wr);
        return rd | (|wr);
    endfunction

endpackage

// File: rtl/tcm_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to the requester that did not win last time.
module tcm_rr_pick2 (
    input  logic [1:0] pend,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // Winner selection
    always_comb begin
        grant_valid = |pend;
        case (pend)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/tcm_ext_arbiter.sv
// Round-robin arbiter and sequencer for the TCM external RAM port: one command
// at a time, fixed issue/capture/ack sequence, then a programmable idle gap.
module tcm_ext_arbiter
    import tcm_ext_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_rd_i,
    input  logic [3:0]  req0_wr_i,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_data_i,
    output logic        req0_accept_o,
    output logic        req0_ack_o,
    output logic [31:0] req0_data_o,
    input  logic        req1_rd_i,
    input  logic [3:0]  req1_wr_i,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_data_i,
    output logic        req1_accept_o,
    output logic        req1_ack_o,
    output logic [31:0] req1_data_o,
    output logic        ext_rd_o,
    output logic [3:0]  ext_wr_o,
    output logic [31:0] ext_addr_o,
    output logic [31:0] ext_write_data_o,
    input  logic        ext_accept_i,
    input  logic [31:0] ext_read_data_i,
    output logic        busy_o
);

    arb_state_t           state_r, state_s;
    logic                 take_s;
    logic                 grant_valid_s, grant_id_s;
    logic                 last_grant_r;
    logic [GAP_CNT_W-1:0] gap_cnt_r;
    logic [31:0]          addr_r, wdata_r, data0_r, data1_r;
    logic [3:0]           wr_r;
    logic                 rd_r, gid_r, ack0_r, ack1_r;
    logic                 sel_rd_s;
    logic [3:0]           sel_wr_s;
    logic [31:0]          sel_addr_s, sel_data_s;

    tcm_rr_pick2 u_pick (
        .pend        ({cmd_pending(req1_rd_i, req1_wr_i), cmd_pending(req0_rd_i, req0_wr_i)}),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Command mux from the winning requester
    always_comb begin
        if (grant_id_s) begin
            sel_rd_s   = req1_rd_i;
            sel_wr_s   = req1_wr_i;
            sel_addr_s = req1_addr_i;
            sel_data_s = req1_data_i;
        end else begin
            sel_rd_s   = req0_rd_i;
            sel_wr_s   = req0_wr_i;
            sel_addr_s = req0_addr_i;
            sel_data_s = req0_data_i;
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        state_s = state_r;
        take_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    take_s  = 1'b1;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ext_accept_i) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_CAPTURE: state_s = ST_ACK;
            ST_ACK:     state_s = ST_GAP;
            ST_GAP: begin
                if (gap_cnt_r <= 4'd1) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, command latch, gap counter, ack and read-data registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            gap_cnt_r    <= 4'd0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            wr_r         <= 4'd0;
            rd_r         <= 1'b0;
            gid_r        <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            data0_r      <= 32'd0;
            data1_r      <= 32'd0;
        end else begin
            state_r <= state_s;
            if (take_s) begin
                addr_r       <= sel_addr_s;
                wdata_r      <= sel_data_s;
                wr_r         <= sel_wr_s;
                // Any write strobe turns the command into a write
                rd_r         <= sel_rd_s & ~(|sel_wr_s);
                gid_r        <= grant_id_s;
                last_grant_r <= grant_id_s;
            end
            if (state_r == ST_ACK) begin
                gap_cnt_r <= 4'(GAP_CYCLES);
            end else if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r - 4'd1;
            end
            ack0_r <= (state_r == ST_CAPTURE) && !gid_r;
            ack1_r <= (state_r == ST_CAPTURE) && gid_r;
            if (state_r == ST_CAPTURE && rd_r && !gid_r) begin
                data0_r <= ext_read_data_i;
            end
            if (state_r == ST_CAPTURE && rd_r && gid_r) begin
                data1_r <= ext_read_data_i;
            end
        end
    end

    assign req0_accept_o    = take_s & ~grant_id_s;
    assign req1_accept_o    = take_s & grant_id_s;
    assign req0_ack_o       = ack0_r;
    assign req1_ack_o       = ack1_r;
    assign req0_data_o      = data0_r;
    assign req1_data_o      = data1_r;
    assign ext_rd_o         = (state_r == ST_ISSUE) & rd_r;
    assign ext_wr_o         = (state_r == ST_ISSUE) ? wr_r : 4'd0;
    assign ext_addr_o       = addr_r;
    assign ext_write_data_o = wdata_r;
    assign busy_o           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_tcm_ext_arbiter.sv
// Directed bench for tcm_ext_arbiter with a small TCM external-port model
// that accepts on the second cycle of each command.
module tb_tcm_ext_arbiter;

    localparam int GAP = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req0_rd_i = 1'b0, req1_rd_i = 1'b0;
    logic [3:0]  req0_wr_i = 4'd0, req1_wr_i = 4'd0;
    logic [31:0] req0_addr_i = 32'd0, req1_addr_i = 32'd0;
    logic [31:0] req0_data_i = 32'd0, req1_data_i = 32'd0;
    logic        req0_accept_o, req1_accept_o, req0_ack_o, req1_ack_o;
    logic [31:0] req0_data_o, req1_data_o;
    logic        ext_rd_o, ext_accept_i, busy_o;
    logic [3:0]  ext_wr_o;
    logic [31:0] ext_addr_o, ext_write_data_o, ext_read_data_i;

    tcm_ext_arbiter #(.GAP_CYCLES(GAP)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_rd_i(req0_rd_i), .req0_wr_i(req0_wr_i), .req0_addr_i(req0_addr_i),
        .req0_data_i(req0_data_i), .req0_accept_o(req0_accept_o), .req0_ack_o(req0_ack_o),
        .req0_data_o(req0_data_o),
        .req1_rd_i(req1_rd_i), .req1_wr_i(req1_wr_i), .req1_addr_i(req1_addr_i),
        .req1_data_i(req1_data_i), .req1_accept_o(req1_accept_o), .req1_ack_o(req1_ack_o),
        .req1_data_o(req1_data_o),
        .ext_rd_o(ext_rd_o), .ext_wr_o(ext_wr_o), .ext_addr_o(ext_addr_o),
        .ext_write_data_o(ext_write_data_o), .ext_accept_i(ext_accept_i),
        .ext_read_data_i(ext_read_data_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // TCM external port model
    logic [31:0] mem [0:63];
    logic        prev_cmd;
    logic        cmd_w;
    assign cmd_w        = ext_rd_o | (|ext_wr_o);
    assign ext_accept_i = cmd_w & prev_cmd;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_cmd <= 1'b0;
        end else begin
            prev_cmd <= cmd_w & ~ext_accept_i;
            if (ext_accept_i) begin
                for (int b = 0; b < 4; b++)
                    if (ext_wr_o[b]) mem[ext_addr_o[7:2]][8*b +: 8] <= ext_write_data_o[8*b +: 8];
                ext_read_data_i <= mem[ext_addr_o[7:2]];
            end
        end
    end

    // Monitors, sampled on the falling edge
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int acc_id_q[$];
    int acc_cyc_q[$];
    int ack0_n = 0, ack1_n = 0, wr_cyc_n = 0, rd_cyc_n = 0;
    int low_run = 0, min_low = 1000;
    bit seen_cmd = 1'b0;
    logic [3:0] last_wr = 4'd0;

    always @(negedge clk_i) begin
        if (req0_accept_o) begin acc_id_q.push_back(0); acc_cyc_q.push_back(cyc); end
        if (req1_accept_o) begin acc_id_q.push_back(1); acc_cyc_q.push_back(cyc); end
        if (req0_ack_o) ack0_n++;
        if (req1_ack_o) ack1_n++;
        if (ext_rd_o) rd_cyc_n++;
        if (ext_wr_o != 4'd0) begin wr_cyc_n++; last_wr = ext_wr_o; end
        if (ext_rd_o || ext_wr_o != 4'd0) begin
            if (seen_cmd && low_run > 0 && low_run < min_low) min_low = low_run;
            low_run  = 0;
            seen_cmd = 1'b1;
        end else begin
            low_run++;
        end
    end

    int n_total = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit id, input logic rd, input logic [3:0] wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (id) begin
            req1_rd_i = rd; req1_wr_i = wr; req1_addr_i = a; req1_data_i = d;
        end else begin
            req0_rd_i = rd; req0_wr_i = wr; req0_addr_i = a; req0_data_i = d;
        end
    endtask

    task automatic issue(input bit id, input logic rd, input logic [3:0] wr,
                         input logic [31:0] a, input logic [31:0] d, output int acc_at);
        @(posedge clk_i); #1;
        drive(id, rd, wr, a, d);
        acc_at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if ((!id && req0_accept_o) || (id && req1_accept_o)) begin
                acc_at = cyc;
                break;
            end
        end
        check_eq("accept_seen", 32'(acc_at >= 0), 32'd1);
        @(posedge clk_i); #1;
        drive(id, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic wait_ack(input bit id, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if ((!id && req0_ack_o) || (id && req1_ack_o)) begin
                at = cyc;
                break;
            end
        end
        check_eq("ack_seen", 32'(at >= 0), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin ok = 1'b1; break; end
        end
        check_eq("idle_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_accepts(input int target);
        for (int i = 0; i < 200 && acc_id_q.size() < target; i++) @(negedge clk_i);
        check_eq("accept_count", 32'(acc_id_q.size()), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=stuck exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t_acc, t_ack, base, wr0, rd0, a0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_ext_wr", 32'(ext_wr_o), 32'd0);
        check_eq("rst_ext_rd", 32'(ext_rd_o), 32'd0);
        check_eq("rst_ext_addr", ext_addr_o, 32'd0);
        check_eq("rst_data0", req0_data_o, 32'd0);
        check_eq("rst_ack", 32'({req0_ack_o, req1_ack_o}), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // 1: single write then read back
        wr0 = wr_cyc_n;
        issue(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, t_acc);
        wait_ack(1'b0, t_ack);
        check_eq("t1_ack_lat", 32'(t_ack - t_acc), 32'd4);
        check_eq("t1_wr_cycles", 32'(wr_cyc_n - wr0), 32'd2);
        check_eq("t1_wr_strobe", 32'(last_wr), 32'hF);
        issue(1'b0, 1'b1, 4'd0, 32'h0000_0010, 32'd0, t_acc);
        wait_ack(1'b0, t_ack);
        check_eq("t1_rd_lat", 32'(t_ack - t_acc), 32'd4);
        check_eq("t1_rd_data", req0_data_o, 32'hDEAD_BEEF);

        // 3: byte write into a preloaded word
        issue(1'b1, 1'b0, 4'hF, 32'h0000_0030, 32'h1122_3344, t_acc);
        wait_ack(1'b1, t_ack);
        issue(1'b1, 1'b0, 4'b0010, 32'h0000_0030, 32'h0000_AB00, t_acc);
        wait_ack(1'b1, t_ack);
        issue(1'b1, 1'b1, 4'd0, 32'h0000_0030, 32'd0, t_acc);
        wait_ack(1'b1, t_ack);
        check_eq("t3_byte_rb", req1_data_o, 32'h1122_AB44);
        check_eq("t3_data0_hold", req0_data_o, 32'hDEAD_BEEF);
        wait_idle();

        // 2: both pending after reset, six reads alternate with fixed spacing
        @(posedge clk_i); #1; rst_i = 1'b1;
        @(posedge clk_i); #1; rst_i = 1'b0;
        base = acc_id_q.size();
        drive(1'b0, 1'b1, 4'd0, 32'h0000_0010, 32'd0);
        drive(1'b1, 1'b1, 4'd0, 32'h0000_0030, 32'd0);
        wait_accepts(base + 6);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        wait_idle();
        for (int k = 0; k < 6; k++)
            if (base + k < acc_id_q.size())
                check_eq($sformatf("t2_grant%0d", k), 32'(acc_id_q[base+k]), 32'(k % 2));
        for (int k = 1; k < 6; k++)
            if (base + k < acc_cyc_q.size())
                check_eq($sformatf("t2_spacing%0d", k),
                         32'(acc_cyc_q[base+k] - acc_cyc_q[base+k-1]), 32'd7);
        check_eq("t2_rd_data0", req0_data_o, 32'hDEAD_BEEF);
        check_eq("t2_rd_data1", req1_data_o, 32'h1122_AB44);

        // 4: req1 streams writes; command must stay low at least GAP cycles between
        base = acc_id_q.size();
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0060, 32'hA5A5_A5A5);
        wait_accepts(base + 4);
        @(posedge clk_i); #1;
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        wait_idle();
        check_eq("t4_min_low_ge_gap", 32'(min_low >= GAP), 32'd1);
        check_eq("t4_mem", mem[6'h18], 32'hA5A5_A5A5);

        // 5: reset during the first ISSUE cycle drops the command
        issue(1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'h5555_5555, t_acc);
        wait_ack(1'b0, t_ack);
        wait_idle();
        a0 = ack0_n;
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'hCAFE_F00D);
        @(negedge clk_i);
        check_eq("t5_accept", 32'(req0_accept_o), 32'd1);
        @(posedge clk_i); #1;
        check_eq("t5_issue_wr", 32'(ext_wr_o), 32'hF);
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        check_eq("t5_wr_dropped", 32'(ext_wr_o), 32'd0);
        check_eq("t5_busy_dropped", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1; rst_i = 1'b0;
        repeat (8) @(posedge clk_i);
        #1;
        check_eq("t5_no_ack", 32'(ack0_n - a0), 32'd0);
        check_eq("t5_word_kept", mem[6'h10], 32'h5555_5555);
        check_eq("t5_data0_rst", req0_data_o, 32'd0);
        drive(1'b0, 1'b1, 4'd0, 32'h0000_0010, 32'd0);
        drive(1'b1, 1'b1, 4'd0, 32'h0000_0030, 32'd0);
        @(negedge clk_i);
        check_eq("t5_tie_acc0", 32'(req0_accept_o), 32'd1);
        check_eq("t5_tie_acc1", 32'(req1_accept_o), 32'd0);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        wait_ack(1'b0, t_ack);
        check_eq("t5_rd_data0", req0_data_o, 32'hDEAD_BEEF);
        wait_idle();

        // 6: rd together with wr strobes is a write; data_o holds
        rd0 = rd_cyc_n;
        wr0 = wr_cyc_n;
        issue(1'b0, 1'b1, 4'hF, 32'h0000_0050, 32'h1234_5678, t_acc);
        wait_ack(1'b0, t_ack);
        check_eq("t6_data0_hold", req0_data_o, 32'hDEAD_BEEF);
        check_eq("t6_no_rd", 32'(rd_cyc_n - rd0), 32'd0);
        check_eq("t6_wr_cycles", 32'(wr_cyc_n - wr0), 32'd2);
        wait_idle();
        check_eq("t6_mem", mem[6'h14], 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
